// File: rtl/pipe_fanout.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fanout
// Brief    : Broadcast driver stage fanned out to per-channel repeater chains
//            with capture registers and saturating capture counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fanout #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 1,
    parameter int CNT_W    = 8
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*CNT_W-1:0] cap_cnt,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                r_drv_valid;
    logic [WIDTH-1:0]    r_drv_data;
    logic [CHANNELS-1:0] r_drv_tag;
    logic [CHANNELS-1:0] w_rep_busy;

    // The enable mask is frozen into the tag here; downstream never looks at ch_en.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_drv_valid <= 1'b0;
            r_drv_data  <= '0;
            r_drv_tag   <= '0;
        end else begin
            r_drv_valid <= in_valid;
            if (in_valid) begin
                r_drv_data <= in_data;
                r_drv_tag  <= ch_en;
            end
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic             w_arr_valid;
            logic             w_arr_tag;
            logic [WIDTH-1:0] w_arr_data;
            logic             w_cap;
            logic             r_out_valid;
            logic [WIDTH-1:0] r_out_data;
            logic [CNT_W-1:0] r_cnt;

            if (STAGES == 0) begin : g_direct
                assign w_arr_valid   = r_drv_valid;
                assign w_arr_tag     = r_drv_tag[c];
                assign w_arr_data    = r_drv_data;
                assign w_rep_busy[c] = 1'b0;
            end else begin : g_rep
                logic [STAGES-1:0] r_valid;
                logic [STAGES-1:0] r_tag;
                logic [WIDTH-1:0]  r_data [STAGES];

                always_ff @(posedge clk1 or posedge rst) begin
                    if (rst) begin
                        r_valid <= '0;
                        r_tag   <= '0;
                        for (int s = 0; s < STAGES; s++) begin
                            r_data[s] <= '0;
                        end
                    end else begin
                        r_valid[0] <= r_drv_valid;
                        r_tag[0]   <= r_drv_tag[c];
                        r_data[0]  <= r_drv_data;
                        for (int s = 1; s < STAGES; s++) begin
                            r_valid[s] <= r_valid[s-1];
                            r_tag[s]   <= r_tag[s-1];
                            r_data[s]  <= r_data[s-1];
                        end
                    end
                end

                assign w_arr_valid   = r_valid[STAGES-1];
                assign w_arr_tag     = r_tag[STAGES-1];
                assign w_arr_data    = r_data[STAGES-1];
                assign w_rep_busy[c] = |r_valid;
            end

            assign w_cap = w_arr_valid & w_arr_tag;

            // Clear takes priority over a coincident capture.
            always_ff @(posedge clk1 or posedge rst) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_out_valid <= w_cap;
                    if (w_cap) begin
                        r_out_data <= w_arr_data;
                    end
                    if (cnt_clr) begin
                        r_cnt <= '0;
                    end else if (w_cap && (r_cnt != c_cnt_max)) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
            end

            assign out_valid[c]                 = r_out_valid;
            assign out_data[c*WIDTH +: WIDTH]   = r_out_data;
            assign cap_cnt[c*CNT_W +: CNT_W]    = r_cnt;
        end
    endgenerate

    assign busy = r_drv_valid | (|w_rep_busy);

endmodule
`default_nettype wire

// File: tb/tb_pipe_fanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fanout
// Brief    : Directed self-checking bench for pipe_fanout over four configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fanout;

    logic clk1;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // A: WIDTH=1 CHANNELS=2 STAGES=1 CNT_W=8
    logic         a_in_valid, a_cnt_clr, a_busy;
    logic [0:0]   a_in_data;
    logic [1:0]   a_ch_en, a_out_valid, a_out_data;
    logic [15:0]  a_cap_cnt;
    // B: WIDTH=1 CHANNELS=2 STAGES=2 CNT_W=2
    logic         b_in_valid, b_cnt_clr, b_busy;
    logic [0:0]   b_in_data;
    logic [1:0]   b_ch_en, b_out_valid, b_out_data;
    logic [3:0]   b_cap_cnt;
    // C: WIDTH=4 CHANNELS=2 STAGES=3 CNT_W=8
    logic         c_in_valid, c_cnt_clr, c_busy;
    logic [3:0]   c_in_data;
    logic [1:0]   c_ch_en, c_out_valid;
    logic [7:0]   c_out_data;
    logic [15:0]  c_cap_cnt;
    // D: WIDTH=8 CHANNELS=16 STAGES=0 CNT_W=8
    logic         d_in_valid, d_cnt_clr, d_busy;
    logic [7:0]   d_in_data;
    logic [15:0]  d_ch_en, d_out_valid;
    logic [127:0] d_out_data, d_cap_cnt;

    pipe_fanout #(.WIDTH(1), .CHANNELS(2), .STAGES(1), .CNT_W(8)) u_a (
        .clk1(clk1), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .ch_en(a_ch_en),
        .cnt_clr(a_cnt_clr), .out_valid(a_out_valid), .out_data(a_out_data),
        .cap_cnt(a_cap_cnt), .busy(a_busy));
    pipe_fanout #(.WIDTH(1), .CHANNELS(2), .STAGES(2), .CNT_W(2)) u_b (
        .clk1(clk1), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .ch_en(b_ch_en),
        .cnt_clr(b_cnt_clr), .out_valid(b_out_valid), .out_data(b_out_data),
        .cap_cnt(b_cap_cnt), .busy(b_busy));
    pipe_fanout #(.WIDTH(4), .CHANNELS(2), .STAGES(3), .CNT_W(8)) u_c (
        .clk1(clk1), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data), .ch_en(c_ch_en),
        .cnt_clr(c_cnt_clr), .out_valid(c_out_valid), .out_data(c_out_data),
        .cap_cnt(c_cap_cnt), .busy(c_busy));
    pipe_fanout #(.WIDTH(8), .CHANNELS(16), .STAGES(0), .CNT_W(8)) u_d (
        .clk1(clk1), .rst(rst), .in_valid(d_in_valid), .in_data(d_in_data), .ch_en(d_ch_en),
        .cnt_clr(d_cnt_clr), .out_valid(d_out_valid), .out_data(d_out_data),
        .cap_cnt(d_cap_cnt), .busy(d_busy));

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_ch_en = 0; a_cnt_clr = 0;
        b_in_valid = 0; b_in_data = 0; b_ch_en = 0; b_cnt_clr = 0;
        c_in_valid = 0; c_in_data = 0; c_ch_en = 0; c_cnt_clr = 0;
        d_in_valid = 0; d_in_data = 0; d_ch_en = 0; d_cnt_clr = 0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({a_out_valid, a_out_data, a_cap_cnt, a_busy} !== 21'h0) begin
            n_fail++; $display("FAIL reset_a: got %h required 0", {a_out_valid, a_out_data, a_cap_cnt, a_busy});
        end
        n_checks++;
        if ({b_out_valid, b_out_data, b_cap_cnt, b_busy} !== 9'h0) begin
            n_fail++; $display("FAIL reset_b: got %h required 0", {b_out_valid, b_out_data, b_cap_cnt, b_busy});
        end
        n_checks++;
        if ({c_out_valid, c_out_data, c_cap_cnt, c_busy} !== 27'h0) begin
            n_fail++; $display("FAIL reset_c: got %h required 0", {c_out_valid, c_out_data, c_cap_cnt, c_busy});
        end
        n_checks++;
        if ({d_out_valid, d_out_data, d_cap_cnt, d_busy} !== 273'h0) begin
            n_fail++; $display("FAIL reset_d: got %h required 0", {d_out_valid, d_out_data, d_cap_cnt, d_busy});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_broadcast();
        a_in_valid = 1; a_in_data = 1; a_ch_en = 2'b11;
        tick();
        a_in_valid = 0; a_in_data = 0; a_ch_en = 2'b00;
        n_checks++;
        if (a_busy !== 1'b1 || a_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL bcast_stage1: busy=%b valid=%b required busy=1 valid=00", a_busy, a_out_valid);
        end
        tick();
        n_checks++;
        if (a_busy !== 1'b1 || a_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL bcast_stage2: busy=%b valid=%b required busy=1 valid=00", a_busy, a_out_valid);
        end
        tick();
        n_checks++;
        if (a_out_valid !== 2'b11 || a_out_data !== 2'b11 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL bcast_capture: valid=%b data=%b busy=%b required 11 11 0", a_out_valid, a_out_data, a_busy);
        end
        n_checks++;
        if (a_cap_cnt !== 16'h0101) begin
            n_fail++; $display("FAIL bcast_count: got %h required 0101", a_cap_cnt);
        end
        tick();
        n_checks++;
        if (a_out_valid !== 2'b00 || a_out_data !== 2'b11) begin
            n_fail++; $display("FAIL bcast_hold: valid=%b data=%b required 00 11", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_enable_sampling();
        a_in_valid = 1; a_in_data = 0; a_ch_en = 2'b01;
        tick();
        a_in_valid = 0; a_ch_en = 2'b10;
        tick();
        tick();
        n_checks++;
        if (a_out_valid !== 2'b01 || a_out_data !== 2'b10) begin
            n_fail++; $display("FAIL en_sample: valid=%b data=%b required 01 10", a_out_valid, a_out_data);
        end
        n_checks++;
        if (a_cap_cnt !== 16'h0102) begin
            n_fail++; $display("FAIL en_count: got %h required 0102", a_cap_cnt);
        end
        tick();
        a_ch_en = 2'b00;
        n_checks++;
        if (a_out_valid !== 2'b00 || a_cap_cnt !== 16'h0102) begin
            n_fail++; $display("FAIL en_after: valid=%b cnt=%h required 00 0102", a_out_valid, a_cap_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic       seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] exp_v, exp_d;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                b_in_valid = 1; b_in_data = seq[k]; b_ch_en = 2'b11;
            end else begin
                b_in_valid = 0; b_in_data = 0;
            end
            tick();
            if (k >= 3 && k <= 6) begin
                exp_v = 2'b11; exp_d = {2{seq[k-3]}};
            end else begin
                exp_v = 2'b00; exp_d = (k > 6) ? {2{seq[3]}} : 2'b00;
            end
            n_checks++;
            if (b_out_valid !== exp_v || b_out_data !== exp_d) begin
                n_fail++; $display("FAIL b2b_cycle%0d: valid=%b data=%b required %b %b", k, b_out_valid, b_out_data, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] e;
        int         caps;
        b_cnt_clr = 1;
        tick();
        b_cnt_clr = 0;
        n_checks++;
        if (b_cap_cnt !== 4'h0) begin
            n_fail++; $display("FAIL sat_clear: got %h required 0", b_cap_cnt);
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                b_in_valid = 1; b_in_data = 1; b_ch_en = 2'b11;
            end else begin
                b_in_valid = 0;
            end
            tick();
            caps = (k < 2) ? 0 : ((k - 2 > 5) ? 5 : k - 2);
            e = (caps > 3) ? 2'd3 : 2'(caps);
            n_checks++;
            if (b_cap_cnt !== {e, e}) begin
                n_fail++; $display("FAIL sat_cycle%0d: got %h required %h", k, b_cap_cnt, {e, e});
            end
        end
        b_in_valid = 1; b_in_data = 1; b_ch_en = 2'b11;
        tick();
        b_in_valid = 0;
        tick();
        tick();
        b_cnt_clr = 1;
        tick();
        n_checks++;
        if (b_out_valid !== 2'b11 || b_cap_cnt !== 4'h0) begin
            n_fail++; $display("FAIL clr_wins: valid=%b cnt=%h required 11 0", b_out_valid, b_cap_cnt);
        end
        b_cnt_clr = 0;
        tick();
        n_checks++;
        if (b_out_valid !== 2'b00 || b_cap_cnt !== 4'h0) begin
            n_fail++; $display("FAIL clr_after: valid=%b cnt=%h required 00 0", b_out_valid, b_cap_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] exp_v;
        c_in_valid = 1; c_in_data = 4'h9; c_ch_en = 2'b11;
        tick();
        c_in_valid = 0;
        repeat (4) tick();
        n_checks++;
        if (c_out_data !== 8'h99 || c_cap_cnt !== 16'h0101) begin
            n_fail++; $display("FAIL ar_precap: data=%h cnt=%h required 99 0101", c_out_data, c_cap_cnt);
        end
        c_in_valid = 1; c_in_data = 4'h5;
        tick();
        c_in_data = 4'h6;
        tick();
        c_in_valid = 0; c_in_data = 0;
        n_checks++;
        if (c_busy !== 1'b1) begin
            n_fail++; $display("FAIL ar_inflight: busy=%b required 1", c_busy);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({c_out_valid, c_out_data, c_cap_cnt, c_busy} !== 27'h0) begin
            n_fail++; $display("FAIL ar_immediate: got %h required 0", {c_out_valid, c_out_data, c_cap_cnt, c_busy});
        end
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (c_out_valid !== 2'b00) begin
                n_fail++; $display("FAIL ar_discard_cycle%0d: valid=%b required 00", k, c_out_valid);
            end
        end
        c_in_valid = 1; c_in_data = 4'hA; c_ch_en = 2'b01;
        for (int k = 0; k < 7; k++) begin
            tick();
            c_in_valid = 0;
            exp_v = (k == 4) ? 2'b01 : 2'b00;
            n_checks++;
            if (c_out_valid !== exp_v) begin
                n_fail++; $display("FAIL ar_latency_cycle%0d: valid=%b required %b", k, c_out_valid, exp_v);
            end
        end
        n_checks++;
        if (c_out_data !== 8'h0A || c_cap_cnt !== 16'h0001) begin
            n_fail++; $display("FAIL ar_recapture: data=%h cnt=%h required 0a 0001", c_out_data, c_cap_cnt);
        end
    endtask

    task automatic test_wide();
        logic [15:0]  exp_v;
        logic [127:0] exp_d, exp_c;
        for (int k = 0; k < 9; k++) begin
            if (k < 6) begin
                d_in_valid = 1; d_in_data = 8'(16 + k);
                d_ch_en = (k % 2 != 0) ? 16'h5555 : 16'hAAAA;
            end else begin
                d_in_valid = 0; d_in_data = 0; d_ch_en = 0;
            end
            tick();
            if (k >= 1 && k <= 6) exp_v = ((k - 1) % 2 != 0) ? 16'h5555 : 16'hAAAA;
            else exp_v = 16'h0000;
            n_checks++;
            if (d_out_valid !== exp_v || d_busy !== (k < 6)) begin
                n_fail++; $display("FAIL wide_cycle%0d: valid=%h busy=%b required %h %b", k, d_out_valid, d_busy, exp_v, (k < 6));
            end
        end
        for (int c = 0; c < 16; c++) begin
            exp_d[c*8 +: 8] = (c % 2 != 0) ? 8'h14 : 8'h15;
            exp_c[c*8 +: 8] = 8'd3;
        end
        n_checks++;
        if (d_out_data !== exp_d) begin
            n_fail++; $display("FAIL wide_data: got %h required %h", d_out_data, exp_d);
        end
        n_checks++;
        if (d_cap_cnt !== exp_c) begin
            n_fail++; $display("FAIL wide_count: got %h required %h", d_cap_cnt, exp_c);
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_enable_sampling();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
